// File: rtl/mem_arb_pkg.sv
// Package: mem_arb_pkg
// Shared types and helpers for the instruction/data RAM port arbiter.
//   arb_state_t  : transaction sequencer states (IDLE, IBUSY, DBUSY)
//   GRANT_I/D    : encoding of the grant / address-mux select
//   fixed_grant  : D-over-I priority pick
//   rr_grant     : alternating pick used when both requesters contend
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Data side always wins when it is requesting.
    function automatic logic fixed_grant(input logic dreq);
        return dreq ? GRANT_D : GRANT_I;
    endfunction

    // On contention the side that was not served last wins; a lone request
    // is granted directly.
    function automatic logic rr_grant(input logic ireq, input logic dreq,
                                      input logic last_grant);
        if (ireq && dreq) begin
            return ~last_grant;
        end
        return dreq ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Interface: mem_bus_arbiter_if
// Bundles the fetch/LSU request side and the RAM side of the shared memory port.
//   Requests : iren, iaddr, dren, dwen, daddr, dstore
//   Responses: ihit, iload, dhit, dload, bus_err, mux_sel
//   RAM      : ram_ren, ram_wen, ramaddr, ramstore (to RAM); ram_ready, ramload (from RAM)
// Modports:
//   master : the arbiter, which owns the RAM strobes and the hit responses
//   slave  : the environment (fetch stage, LSU and RAM model)
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              iren;
    logic [ADDR_W-1:0] iaddr;
    logic              dren;
    logic              dwen;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ram_ready;
    logic [DATA_W-1:0] ramload;

    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              mux_sel;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              bus_err;

    modport master (
        input  iren, iaddr, dren, dwen, daddr, dstore, ram_ready, ramload,
        output ram_ren, ram_wen, ramaddr, ramstore, mux_sel,
               ihit, iload, dhit, dload, bus_err
    );

    modport slave (
        output iren, iaddr, dren, dwen, daddr, dstore, ram_ready, ramload,
        input  ram_ren, ram_wen, ramaddr, ramstore, mux_sel,
               ihit, iload, dhit, dload, bus_err
    );

endinterface

// File: rtl/arb_wait_timer.sv
// Module: arb_wait_timer
// Watchdog counter for RAM wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted on entry to a busy state)
//   inc        : one more busy cycle without ram_ready
//   expired    : the current stall cycle is the TIMEOUT_CYC-th one
module arb_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates so a stuck inc can never wrap back below the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q already holds the stalls seen so far; one more stall reaches the limit.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Module: mem_bus_arbiter
// Shares the single RAM port between instruction fetch (I) and data access (D).
// A grant is registered from IDLE, the address/store/op are latched, and the
// access runs in IBUSY or DBUSY until ram_ready (hit) or the wait watchdog fires
// (sticky bus_err, no hit). One IDLE cycle always separates transactions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_bus_arbiter_if.master (requests, RAM strobes, hits, bus_err)
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYC (>= 2)
// Build option: ARB_ROUND_ROBIN_EN selects alternating grant on contention
//   (last_grant register, reset to D); otherwise fixed D-over-I priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               rst_n,
    mem_bus_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    logic              mux_sel_q, mux_sel_d;
    logic              op_ren_q, op_ren_d;
    logic              op_wen_q, op_wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              bus_err_q, bus_err_d;

    logic ireq, dreq, grant;
    logic timer_clear, timer_inc, timer_expired;
    logic ren, wen, ihit, dhit;

    assign ireq = bus.iren;
    assign dreq = bus.dren | bus.dwen;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign grant = rr_grant(ireq, dreq, last_grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && (ireq || dreq)) begin
            last_grant_d = grant;
        end
    end
`else
    assign grant = fixed_grant(dreq);
`endif

    arb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        mux_sel_d   = mux_sel_q;
        op_ren_d    = op_ren_q;
        op_wen_d    = op_wen_q;
        addr_d      = addr_q;
        store_d     = store_q;
        bus_err_d   = bus_err_q;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        ihit        = 1'b0;
        dhit        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ireq || dreq) begin
                    mux_sel_d   = grant;
                    timer_clear = 1'b1;
                    // Inline 2:1 mux on the new select value; latched for the whole access.
                    addr_d  = (mux_sel_d == GRANT_D) ? bus.daddr : bus.iaddr;
                    store_d = (mux_sel_d == GRANT_D) ? bus.dstore : '0;
                    // A D request with dwen set is a write even if dren is also high.
                    op_wen_d = (mux_sel_d == GRANT_D) && bus.dwen;
                    op_ren_d = ~op_wen_d;
                    state_d  = (mux_sel_d == GRANT_D) ? DBUSY : IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                ren = op_ren_q;
                wen = op_wen_q;
                // ram_ready takes precedence over a timeout landing on the same cycle.
                if (bus.ram_ready) begin
                    ihit    = (state_q == IBUSY);
                    dhit    = (state_q == DBUSY);
                    state_d = IDLE;
                end else if (timer_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mux_sel_q <= GRANT_D;
            op_ren_q  <= 1'b0;
            op_wen_q  <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            op_ren_q  <= op_ren_d;
            op_wen_q  <= op_wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.ram_ren  = ren;
    assign bus.ram_wen  = wen;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.mux_sel  = mux_sel_q;
    assign bus.ihit     = ihit;
    assign bus.dhit     = dhit;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.bus_err  = bus_err_q;

endmodule
